// File: rtl/seg_time_display_pkg.sv
// Shared constants, segment lookup and FSM state type for the seven-segment
// time display block.
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low gfedcba patterns for the decimal digits 0..9.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {IDLE, CONV, UPD} dispState_e;

  // 10**n, used to check that MAX_VAL fits in the available digits.
  function automatic longint pow10(input int n);
    longint acc;
    acc = 1;
    for (int k = 0; k < n; k++) acc = acc * 10;
    return acc;
  endfunction

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] addThree(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg_time_display_if.sv
// Value handshake between a clock counter (master) and the display (slave).
interface seg_time_display_if #(
  parameter int VAL_W = 6
) ();

  logic             valid_in;
  logic [VAL_W-1:0] value_in;
  logic             ready_out;

  modport master (output valid_in, output value_in, input ready_out);
  modport slave  (input valid_in, input value_in, output ready_out);

endinterface

// File: rtl/seg_digit_decode.sv
// Combinational BCD nibble to active-low gfedcba segment decoder.
module seg_digit_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] bcdIn,
  output logic [6:0] segOut
);

  // Look up the digit pattern; anything above 9 stays dark.
  always_comb begin
    segOut = SEG_BLANK;
    case (bcdIn)
      4'd0: segOut = SEG_DIGIT[0];
      4'd1: segOut = SEG_DIGIT[1];
      4'd2: segOut = SEG_DIGIT[2];
      4'd3: segOut = SEG_DIGIT[3];
      4'd4: segOut = SEG_DIGIT[4];
      4'd5: segOut = SEG_DIGIT[5];
      4'd6: segOut = SEG_DIGIT[6];
      4'd7: segOut = SEG_DIGIT[7];
      4'd8: segOut = SEG_DIGIT[8];
      4'd9: segOut = SEG_DIGIT[9];
      default: segOut = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_time_display.sv
// Binary-to-seven-segment display driver: accepts a value over a valid/ready
// handshake, converts it to BCD with a sequential double-dabble and updates a
// registered segment display with range blanking, leading-zero blanking and
// blinking.
//
//   state | meaning
//   IDLE  | ready for a new value
//   CONV  | double-dabble shifting, one input bit per cycle
//   UPD   | register results into display/bcd/err, pulse upd_done
module seg_time_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int VAL_W      = 6,
  parameter int MAX_VAL    = 59,
  parameter int BLINK_DIV  = 25000000,
  parameter int LZ_BLANK   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seg_time_display_if.slave         inBus,
  input  logic                      blink_en,
  output logic [NUM_DIGITS*7-1:0]   segs_out,
  output logic [NUM_DIGITS*4-1:0]   bcd_out,
  output logic                      err_out,
  output logic                      upd_done
);

  localparam int BCD_W   = NUM_DIGITS * 4;
  localparam int SEG_W   = NUM_DIGITS * 7;
  localparam int SR_W    = BCD_W + VAL_W;
  localparam int CNT_W   = $clog2(VAL_W + 1);
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [VAL_W-1:0]   MAX_V      = VAL_W'(MAX_VAL);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Parameter sanity: fail elaboration rather than build a display that lies.
  if (longint'(MAX_VAL) >= pow10(NUM_DIGITS)) begin : gChkDigits
    $fatal(1, "seg_time_display: MAX_VAL does not fit in NUM_DIGITS digits");
  end
  if (longint'(MAX_VAL) >= (longint'(1) << VAL_W)) begin : gChkWidth
    $fatal(1, "seg_time_display: MAX_VAL does not fit in VAL_W bits");
  end
  if (BLINK_DIV < 2) begin : gChkBlink
    $fatal(1, "seg_time_display: BLINK_DIV must be at least 2");
  end

  dispState_e         state, stateNext;
  logic [SR_W-1:0]    shiftReg;
  logic [SR_W-1:0]    adjusted;
  logic [CNT_W-1:0]   bitCnt;
  logic               pendErr;
  logic [SEG_W-1:0]   dispReg;
  logic [SEG_W-1:0]   dispReset;
  logic [SEG_W-1:0]   decodedDisp;
  logic [BCD_W-1:0]   convBcd;
  logic [6:0]         rawSeg [NUM_DIGITS];
  logic [BLINK_W-1:0] blinkCnt;
  logic               blinkPhase;
  logic               accept;
  logic               outOfRange;

  assign inBus.ready_out = (state == IDLE);
  assign accept          = inBus.valid_in && inBus.ready_out;
  assign outOfRange      = (inBus.value_in > MAX_V);
  assign convBcd         = shiftReg[SR_W-1:VAL_W];

  // Per-digit decode of the converted BCD, with optional leading-zero blanking;
  // also builds the reset-time display, which is simply the value 0.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
    seg_digit_decode uDecode (
      .bcdIn  (convBcd[4*i +: 4]),
      .segOut (rawSeg[i])
    );
    if (i == 0 || LZ_BLANK == 0) begin : gKeep
      assign decodedDisp[7*i +: 7] = rawSeg[i];
      assign dispReset[7*i +: 7]   = SEG_DIGIT[0];
    end else begin : gLzBlank
      assign decodedDisp[7*i +: 7] = (convBcd[BCD_W-1:4*i] == '0) ? SEG_BLANK : rawSeg[i];
      assign dispReset[7*i +: 7]   = SEG_BLANK;
    end
  end

  // One double-dabble step: correct every BCD nibble that would overflow on shift.
  always_comb begin
    adjusted = shiftReg;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      adjusted[VAL_W + 4*d +: 4] = addThree(shiftReg[VAL_W + 4*d +: 4]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // FSM next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) stateNext = outOfRange ? UPD : CONV;
      end
      CONV: begin
        if (bitCnt == CNT_W'(1)) stateNext = UPD;
      end
      UPD:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Conversion datapath and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      pendErr  <= 1'b0;
      bcd_out  <= '0;
      err_out  <= 1'b0;
      upd_done <= 1'b0;
      dispReg  <= dispReset;
    end else begin
      upd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pendErr  <= outOfRange;
            shiftReg <= {{BCD_W{1'b0}}, inBus.value_in};
            bitCnt   <= CNT_W'(VAL_W);
          end
        end
        CONV: begin
          shiftReg <= adjusted << 1;
          bitCnt   <= bitCnt - CNT_W'(1);
        end
        UPD: begin
          upd_done <= 1'b1;
          if (pendErr) begin
            // Out of range: blank everything but keep the last good BCD.
            err_out <= 1'b1;
            dispReg <= {NUM_DIGITS{SEG_BLANK}};
          end else begin
            err_out <= 1'b0;
            bcd_out <= convBcd;
            dispReg <= decodedDisp;
          end
        end
        default: ;
      endcase
    end
  end

  // Blink timer: phase toggles every BLINK_DIV cycles while blinking is enabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !blink_en) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (blinkCnt == BLINK_LAST) begin
      blinkCnt   <= '0;
      blinkPhase <= ~blinkPhase;
    end else begin
      blinkCnt   <= blinkCnt + BLINK_W'(1);
    end
  end

  // Blink only masks the output; the display register itself is untouched.
  assign segs_out = (blink_en && blinkPhase) ? {NUM_DIGITS{SEG_BLANK}} : dispReg;

endmodule

// File: doc/seg_time_display.md
Name: seg_time_display

Overview:
- Parametrised successor to the two-digit 0–59 seven-segment decoder.
- Accepts a binary value through a valid/ready handshake and converts it to BCD with a sequential double-dabble state machine.
- Drives NUM_DIGITS registered, active-low gfedcba segment fields, with out-of-range blanking, optional leading-zero blanking and a blink mode.
- Sits between the clock counters and the board displays.

Parameters:
- NUM_DIGITS, 2: number of decimal digits driven.
- VAL_W, 6: width of the binary input value.
- MAX_VAL, 59: largest displayable value; anything greater is out of range.
- BLINK_DIV, 25000000: clock cycles per blink half-period.
- LZ_BLANK, 0: 1 blanks leading zero digits; the least significant digit is never blanked.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  value_in is valid.
- value_in  in  VAL_W  binary value to display.
- ready_out  out  1  block is able to accept a value.
- blink_en  in  1  enables blinking of the whole display.
- segs_out  out  NUM_DIGITS*7  segment fields; digit i occupies [7i+6:7i], digit 0 is least significant; gfedcba, active-low.
- bcd_out  out  NUM_DIGITS*4  registered BCD of the last accepted in-range value.
- err_out  out  1  last accepted value was greater than MAX_VAL.
- upd_done  out  1  one-cycle pulse when the displayed value changes.

Behaviour:
- Elaboration checks: MAX_VAL < 10**NUM_DIGITS, MAX_VAL < 2**VAL_W, BLINK_DIV >= 2. A violation is a fatal elaboration error.
- Reset: rst_n sampled low on a rising clk edge forces the following state.
  - state=IDLE, bcd_out=0, err_out=0, upd_done=0, blink counter=0, blink phase=0.
  - Display register: every digit shows "0" (1000000). With LZ_BLANK=1, only digit 0 shows "0" and the rest show 1111111.
  - Reset during CONV or UPD aborts the operation; no upd_done pulse is produced.
- ready_out = (state==IDLE). It is combinational from state and therefore 1 during and after reset.
- FSM states: IDLE, CONV, UPD.
  - IDLE: on valid_in && ready_out (edge E0), latch value_in.
    - If value_in > MAX_VAL, go to UPD with the error flag set.
    - Otherwise load the shift register (BCD=0, binary=value_in), set the bit counter to VAL_W, and go to CONV.
  - CONV: each edge applies add-3 to every BCD nibble >= 5, shifts left one bit and decrements the counter. After VAL_W shifts (edge E0+VAL_W), go to UPD.
  - UPD: one edge registers the results, asserts upd_done for exactly the next cycle, and returns to IDLE.
    - In range: bcd_out, the display register and err_out=0.
    - Out of range: all digits 1111111 and err_out=1; bcd_out keeps its previous value.
- Latency:
  - In range: outputs change at edge E0+VAL_W+1, and ready_out returns high in the same cycle.
  - Out of range: outputs change at edge E0+1.
- valid_in while ready_out=0 is ignored. No queuing; value_in is not sampled.
- Leading-zero blanking (LZ_BLANK=1): digit i>0 is blanked if it and all more significant digits are 0.
- Blink:
  - While blink_en=0, the counter and phase are held at 0.
  - While blink_en=1, the counter counts 0..BLINK_DIV-1 and phase toggles when it wraps.
  - segs_out = display register when phase=0 or blink_en=0; all ones when phase=1.
  - The first blank appears BLINK_DIV cycles after blink_en rises.
  - bcd_out, err_out and upd_done are unaffected by blink.
- A non-decimal nibble into the decoder yields 1111111 (defensive; unreachable in range).

Decomposition:
- Package seg_disp_pkg holds:
  - SEG_BLANK = 7'b1111111.
  - SEG_DIGIT[0:9] lookup, active-low gfedcba: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - FSM state enum {IDLE, CONV, UPD}.
- Sub-module seg_digit_decode: 4-bit BCD in, 7-bit segments out, combinational. Instantiated NUM_DIGITS times in a generate loop; it feeds the display register at UPD.

Test Plan:
- Reset with defaults -> segs_out=14'b1000000_1000000, ready_out=1, err_out=0, upd_done=0.
- value_in=59 accepted at E0 -> at E0+7: bcd_out=8'h59, segs_out=0010010_0010000, upd_done high for one cycle, ready_out=1.
- value_in=7: with LZ_BLANK=0 -> segs_out=1000000_1111000; with LZ_BLANK=1 -> 1111111_1111000.
- value_in=60 -> at E0+1: segs_out all ones, err_out=1, bcd_out unchanged. A following value_in=0 -> err_out=0 and display shows "00".
- value_in=12 accepted, then valid_in held with 34 during CONV -> display shows "12". The value 34 is captured only if valid_in is still high once ready_out returns to 1.
- BLINK_DIV=4, blink_en rises at cycle 0 -> segs_out all ones for cycles 4–7 and restored for cycles 8–11. rst_n low mid-CONV -> reset display, no upd_done.
